mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
Collects per-warp memory requests from the SM warp lanes and round-robin arbitrates them into one ordered transaction stream. Buffers that stream in a FIFO and presents it to the DPI memory bridge, one transaction per handshake, with fields matching the DPI memory-transaction layout. Routes returning read data back to the originating warp. Enforces a per-warp cap on outstanding reads and keeps request and stall counters.

Parameters:
NUM_WARPS, 4, number of requesting warp ports (power of 2, >=2)
FIFO_DEPTH, 8, transaction buffer entries (power of 2)
MAX_OUTSTANDING, 4, max un-responded reads per warp (>=1)

Ports:
clk  in  1  core clock
rst_n  in  1  reset
req_valid  in  NUM_WARPS  per-warp request valid
req_ready  out  NUM_WARPS  per-warp request accepted
req_addr  in  NUM_WARPS*32  per-warp byte address, warp i at [32i+31:32i]
req_data  in  NUM_WARPS*32  per-warp write data
req_is_write  in  NUM_WARPS  1=write, 0=read
req_thread_mask  in  NUM_WARPS*32  per-warp active thread mask
out_valid  out  1  transaction available to bridge
out_ready  in  1  bridge consumes transaction
out_txn  out  $bits(mem_txn_t)  address, data, is_write, size, warp_id, thread_mask
rsp_in_valid  in  1  read response from bridge
rsp_in_warp_id  in  32  response owner
rsp_in_data  in  32  response data
rsp_valid  out  NUM_WARPS  per-warp response strobe
rsp_data  out  32  response data, shared across warps
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
req_count  out  64  accepted requests
stall_cycles  out  64  cycles with out_valid && !out_ready
err_bad_rsp  out  1  one-cycle pulse on an illegal response

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports clk and rst_n.

Behaviour:
- Reset (async assert, sync deassert use):
  - FIFO empty; out_valid=0; out_txn=0.
  - rsp_valid=0; rsp_data=0; err_bad_rsp=0.
  - Counters 0; RR pointer 0; all outstanding counts 0.
  - Reset mid-operation discards all buffered and outstanding state.
- Eligibility: warp i is eligible when req_valid[i] && !(req_is_write[i]==0 && outstanding[i]==MAX_OUTSTANDING).
- Arbitration:
  - Grant the first eligible warp searching from the RR pointer upward, modulo NUM_WARPS, and only when the FIFO is not full.
  - req_ready is one-hot or zero, combinational from the grant.
  - Full is evaluated before any same-cycle pop. No ready path from out_ready.
- On grant:
  - Push {req_addr[i], req_data[i], req_is_write[i], size=MEM_ACCESS_SIZE, warp_id=i zero-extended, req_thread_mask[i]}.
  - RR pointer becomes i+1 mod NUM_WARPS. With no grant the pointer holds.
- Output:
  - First-word-fall-through: out_valid = !empty; out_txn = head entry.
  - Pop on out_valid && out_ready.
  - Push-to-out_valid latency is 1 cycle (entry registered).
  - Simultaneous push and pop: count unchanged, order preserved.
- Outstanding reads:
  - outstanding[i] increments when a read from warp i is accepted.
  - It decrements on a valid response for warp i.
  - Both in the same cycle: unchanged.
- Responses, registered, 1-cycle latency:
  - rsp_in_valid with warp_id < NUM_WARPS and outstanding > 0 gives rsp_valid[warp]=1 and rsp_data=rsp_in_data next cycle.
  - Warp_id >= NUM_WARPS, or outstanding == 0 (and not incremented the same cycle): response dropped, no rsp_valid, err_bad_rsp pulses next cycle, counter unchanged (no underflow).
- Counters:
  - req_count increments per push.
  - stall_cycles increments each cycle out_valid && !out_ready.
  - Both wrap at 2^64.
- Writes never expect a response.

Decomposition:
- Package gpu_mem_pkg holds:
  - mem_txn_t packed struct, field order and widths identical to the DPI memory transaction: address 32, data 32, is_write 1, size 32, warp_id 32, thread_mask 32.
  - MEM_ACCESS_SIZE = 4.
  - Warp-id helper widths.
- Sub-module sync_fifo, parameterised width/depth, with push/pop/full/empty/count. Arbiter, outstanding tracking and response routing stay in mem_req_arbiter.

Test Plan:
1. Single write: warp 2 addr 0x1000, data 0xDEADBEEF, write, mask 0xFFFFFFFF, out_ready=1 -> req_ready[2]=1 same cycle; next cycle out_valid=1, out_txn={0x1000, 0xDEADBEEF, 1, 4, 2, 0xFFFFFFFF}; req_count=1.
2. Round-robin: all four warps valid continuously, out_ready=1 -> grants 0,1,2,3,0,1; warp_id sequence on out_txn identical.
3. Backpressure: out_ready=0, warp 0 sends 9 writes -> 8 accepted, fifo_count=8, 9th req_ready=0, stall_cycles increments each cycle; then out_ready=1 -> 8 entries drain in order, 9th accepted after the first pop.
4. Outstanding cap: MAX_OUTSTANDING=2, warp 1 issues 3 reads with no response -> 3rd blocked, warps 0/2/3 still granted; rsp for warp 1 -> 3rd accepted the cycle after.
5. Response routing: outstanding[3]=1, rsp_in warp 3, data 0x1234 -> rsp_valid[3]=1, rsp_data=0x1234 next cycle. rsp_in warp 7 -> err_bad_rsp pulse, no rsp_valid. Response to warp 0 with outstanding 0 -> err_bad_rsp.
6. Reset mid-operation: 5 entries buffered, rst_n low -> out_valid=0, fifo_count=0, counters 0 immediately without a clock edge; after release, first grant goes to warp 0.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// gpu_mem_pkg
//   Shared types and constants for the SM memory request path.
//   mem_txn_t mirrors the DPI memory-transaction layout field for field
//   (MSB first): address, data, is_write, size, warp_id, thread_mask.
// ---------------------------------------------------------------------------
package gpu_mem_pkg;

    // Every lane access is a 32-bit word.
    localparam int unsigned MEM_ACCESS_SIZE = 4;

    // Width of the warp_id field as carried in a transaction.
    localparam int unsigned WARP_ID_W = 32;

    typedef struct packed {
        logic [31:0]          address;
        logic [31:0]          data;
        logic                 is_write;
        logic [31:0]          size;
        logic [WARP_ID_W-1:0] warp_id;
        logic [31:0]          thread_mask;
    } mem_txn_t;

    localparam int unsigned MEM_TXN_W = $bits(mem_txn_t);

    // Bits needed to index n warps (at least one bit).
    function automatic int unsigned warp_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int unsigned count_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is presented
//   combinationally on o_data; o_data reads as zero while empty.
//   Push while full and pop while empty are ignored.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data this cycle
//   i_data       entry to write
//   i_pop        discard the head entry this cycle
//   o_data       head entry (zero when empty)
//   o_full       DEPTH entries held
//   o_empty      no entries held
//   o_count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // o_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//   Round-robin arbitration of per-warp memory requests into one ordered
//   transaction stream, buffered in a FWFT FIFO towards the DPI memory
//   bridge. Tracks outstanding reads per warp (capped at MAX_OUTSTANDING),
//   routes read responses back to their warp, and counts accepted requests
//   and bridge stall cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         per-warp request valid
//   req_ready         per-warp accept (one-hot or zero, combinational)
//   req_addr          per-warp byte address, warp i at [32i+31:32i]
//   req_data          per-warp write data
//   req_is_write      per-warp 1=write, 0=read
//   req_thread_mask   per-warp active thread mask
//   out_valid         transaction available to bridge
//   out_ready         bridge consumes the head transaction
//   out_txn           head transaction (zero when none)
//   rsp_in_valid      read response from bridge
//   rsp_in_warp_id    response owner
//   rsp_in_data       response data
//   rsp_valid         per-warp response strobe (registered)
//   rsp_data          response data shared across warps (registered)
//   fifo_count        transaction buffer occupancy
//   req_count         accepted requests (wraps at 2^64)
//   stall_cycles      cycles with out_valid && !out_ready (wraps at 2^64)
//   err_bad_rsp       one-cycle pulse after an illegal response
// ---------------------------------------------------------------------------
module mem_req_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_WARPS       = 4,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_WARPS-1:0]          req_valid,
    output logic [NUM_WARPS-1:0]          req_ready,
    input  logic [NUM_WARPS*32-1:0]       req_addr,
    input  logic [NUM_WARPS*32-1:0]       req_data,
    input  logic [NUM_WARPS-1:0]          req_is_write,
    input  logic [NUM_WARPS*32-1:0]       req_thread_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output mem_txn_t                      out_txn,
    input  logic                          rsp_in_valid,
    input  logic [31:0]                   rsp_in_warp_id,
    input  logic [31:0]                   rsp_in_data,
    output logic [NUM_WARPS-1:0]          rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [63:0]                   req_count,
    output logic [63:0]                   stall_cycles,
    output logic                          err_bad_rsp
);

    localparam int unsigned IDX_W = warp_idx_width(NUM_WARPS);
    localparam int unsigned OUT_W = count_width(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [OUT_W-1:0]     r_outstanding [NUM_WARPS];
    logic [NUM_WARPS-1:0] r_rsp_valid;
    logic [31:0]          r_rsp_data;
    logic                 r_err_bad_rsp;
    logic [63:0]          r_req_count;
    logic [63:0]          r_stall_cycles;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [NUM_WARPS-1:0] w_eligible;
    logic [IDX_W-1:0]     w_cand;
    logic                 w_grant_vld;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [NUM_WARPS-1:0] w_req_ready;
    mem_txn_t             w_push_txn;
    logic [NUM_WARPS-1:0] w_rd_accept;
    logic                 w_rsp_in_range;
    logic [IDX_W-1:0]     w_rsp_idx;
    logic                 w_rsp_ok;
    logic                 w_rsp_bad;
    logic [NUM_WARPS-1:0] w_rsp_dec;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic [MEM_TXN_W-1:0] w_head;

    // Eligibility and round-robin search. The search index wraps by plain
    // truncation since NUM_WARPS is a power of two. Full is the registered
    // occupancy, so a same-cycle pop never opens a slot for a grant.
    always_comb begin
        w_eligible  = '0;
        w_cand      = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            w_eligible[i] = req_valid[i] &&
                            !(!req_is_write[i] && (r_outstanding[i] == OUT_MAX));
        end
        for (int unsigned k = 0; k < NUM_WARPS; k++) begin
            w_cand = r_rr_ptr + IDX_W'(k);
            if (!w_grant_vld && !w_fifo_full && w_eligible[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // One-hot accept and the transaction assembled from the granted lane.
    always_comb begin
        w_req_ready = '0;
        w_push_txn  = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            if (w_grant_vld && (w_grant_idx == IDX_W'(i))) begin
                w_req_ready[i]         = 1'b1;
                w_push_txn.address     = req_addr[32*i +: 32];
                w_push_txn.data        = req_data[32*i +: 32];
                w_push_txn.is_write    = req_is_write[i];
                w_push_txn.size        = 32'(MEM_ACCESS_SIZE);
                w_push_txn.warp_id     = WARP_ID_W'(i);
                w_push_txn.thread_mask = req_thread_mask[32*i +: 32];
            end
        end
    end

    assign req_ready = w_req_ready;

    // Response legality. A response is legal when its warp already has a
    // read outstanding, or when a read from that warp is accepted in the
    // same cycle (the two then cancel in the counter).
    always_comb begin
        w_rd_accept    = '0;
        w_rsp_dec      = '0;
        w_rsp_in_range = (rsp_in_warp_id < 32'(NUM_WARPS));
        w_rsp_idx      = rsp_in_warp_id[IDX_W-1:0];
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            w_rd_accept[i] = w_req_ready[i] && !req_is_write[i];
        end
        w_rsp_ok  = rsp_in_valid && w_rsp_in_range &&
                    ((r_outstanding[w_rsp_idx] != '0) || w_rd_accept[w_rsp_idx]);
        w_rsp_bad = rsp_in_valid && !w_rsp_ok;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            w_rsp_dec[i] = w_rsp_ok && (w_rsp_idx == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Transaction buffer
    // ------------------------------------------------------------------
    assign w_pop = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (MEM_TXN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_txn_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_grant_vld),
        .i_data  (w_push_txn),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign out_txn   = mem_txn_t'(w_head);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_rr_ptr <= w_grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                r_outstanding[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                case ({w_rd_accept[i], w_rsp_dec[i]})
                    2'b10:   r_outstanding[i] <= r_outstanding[i] + OUT_W'(1);
                    2'b01:   r_outstanding[i] <= r_outstanding[i] - OUT_W'(1);
                    default: r_outstanding[i] <= r_outstanding[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_err_bad_rsp <= 1'b0;
        end else begin
            r_rsp_valid   <= w_rsp_dec;
            r_err_bad_rsp <= w_rsp_bad;
            if (w_rsp_ok) r_rsp_data <= rsp_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_grant_vld)            r_req_count    <= r_req_count + 64'd1;
            if (out_valid && !out_ready) r_stall_cycles <= r_stall_cycles + 64'd1;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign err_bad_rsp  = r_err_bad_rsp;
    assign req_count    = r_req_count;
    assign stall_cycles = r_stall_cycles;

endmodule
